// File: rtl/multiphase_clock_gen.sv
// Multiphase clock generator: NUM_PHASES non-overlapping phase enables derived from clk,
// with free-run, graceful stop and single-step operation plus a wrapping machine-cycle counter.
module multiphase_clock_gen #(
  parameter int NUM_PHASES = 2,
  parameter int HIGH_TICKS = 8,
  parameter int GAP_TICKS  = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          active,
  input  logic                          step_mode,
  input  logic                          step,
  output logic [NUM_PHASES-1:0]         ph,
  output logic                          cycle_start,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          busy,
  output logic [CNT_W-1:0]              cycle_count
);

  localparam int IDX_W    = $clog2(NUM_PHASES);
  localparam int TICK_MAX = (HIGH_TICKS > GAP_TICKS) ? HIGH_TICKS : GAP_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TICK_W-1:0]     HIGH_LAST = TICK_W'(HIGH_TICKS - 1);
  localparam logic [TICK_W-1:0]     GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] PH_ONE    = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [TICK_W-1:0]       tick_r;
  logic [NUM_PHASES-1:0]   ph_r;
  logic                    cycle_start_r;
  logic [IDX_W-1:0]        phase_idx_r;
  logic                    busy_r;
  logic [CNT_W-1:0]        cycle_count_r;
  logic                    go_s;
  logic [IDX_W-1:0]        next_idx_s;

  function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [IDX_W-1:0] idx);
    phase_onehot = PH_ONE << idx;
  endfunction

  // Start request and next phase index for the GAP decision.
  always_comb begin
    go_s       = 1'b0;
    next_idx_s = phase_idx_r + IDX_W'(1);
    if (step_mode) begin
      go_s = step;
    end else begin
      go_s = active;
    end
  end

  // Phase sequencer: IDLE -> (HIGH -> GAP) x NUM_PHASES, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      tick_r        <= '0;
      ph_r          <= '0;
      cycle_start_r <= 1'b0;
      phase_idx_r   <= '0;
      busy_r        <= 1'b0;
      cycle_count_r <= '0;
    end else begin
      cycle_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (go_s) begin
            state_r       <= HIGH;
            tick_r        <= '0;
            phase_idx_r   <= '0;
            ph_r          <= PH_ONE;
            cycle_start_r <= 1'b1;
            busy_r        <= 1'b1;
            cycle_count_r <= cycle_count_r + CNT_W'(1);
          end else begin
            state_r <= IDLE;
          end
        end
        HIGH: begin
          if (tick_r == HIGH_LAST) begin
            state_r <= GAP;
            tick_r  <= '0;
            ph_r    <= '0;
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end
        GAP: begin
          if (tick_r == GAP_LAST) begin
            tick_r <= '0;
            if (phase_idx_r != IDX_LAST) begin
              state_r     <= HIGH;
              phase_idx_r <= next_idx_s;
              ph_r        <= phase_onehot(next_idx_s);
            end else if (go_s && !step_mode) begin
              // Back-to-back free-run cycle: no idle clk, counted as a fresh start.
              state_r       <= HIGH;
              phase_idx_r   <= '0;
              ph_r          <= PH_ONE;
              cycle_start_r <= 1'b1;
              cycle_count_r <= cycle_count_r + CNT_W'(1);
            end else begin
              state_r     <= IDLE;
              phase_idx_r <= '0;
              busy_r      <= 1'b0;
            end
          end else begin
            tick_r <= tick_r + TICK_W'(1);
          end
        end
        default: begin
          state_r       <= IDLE;
          tick_r        <= '0;
          ph_r          <= '0;
          phase_idx_r   <= '0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign ph          = ph_r;
  assign cycle_start = cycle_start_r;
  assign phase_idx   = phase_idx_r;
  assign busy        = busy_r;
  assign cycle_count = cycle_count_r;

endmodule
